// File: rtl/restoring_div_pkg.sv
// restoring_div_pkg: shared FSM state type, CLA group width and counter sizing for the divider.
package restoring_div_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int CLA_W = 4;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/restoring_div_cla_sub.sv
// cla_sub_nbit: a - b as a + ~b + 1 using chained 4-bit lookahead groups; cout=1 means no borrow.
module cla_sub_nbit
  import restoring_div_pkg::*;
#(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         cout
);
  localparam int G = (N + CLA_W - 1) / CLA_W;
  localparam int P = G * CLA_W;
  logic [P-1:0] x, y, g, p, cb, s;
  logic [G:0] c;
  logic unused_pad;
  // Zero-padding both operands keeps the top carry a valid no-borrow flag.
  assign x = P'(a);
  assign y = ~(P'(b));
  assign g = x & y;
  assign p = x ^ y;
  assign c[0] = 1'b1;
  for (genvar i = 0; i < G; i++) begin : grp
    localparam int L = i * CLA_W;
    assign cb[L]   = c[i];
    assign cb[L+1] = g[L] | p[L] & c[i];
    assign cb[L+2] = g[L+1] | p[L+1] & g[L] | p[L+1] & p[L] & c[i];
    assign cb[L+3] = g[L+2] | p[L+2] & g[L+1] | p[L+2] & p[L+1] & g[L] | p[L+2] & p[L+1] & p[L] & c[i];
    assign c[i+1]  = g[L+3] | p[L+3] & g[L+2] | p[L+3] & p[L+2] & g[L+1]
                   | p[L+3] & p[L+2] & p[L+1] & g[L] | (&p[L+3:L]) & c[i];
  end
  assign s = p ^ cb;
  assign diff = s[N-1:0];
  assign cout = c[G];
  assign unused_pad = ^s;
endmodule

// File: rtl/restoring_div.sv
// restoring_div: multi-cycle restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define RESTORING_DIV_SIGNED_EN for two's-complement operands (truncating division).
module restoring_div
  import restoring_div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = cnt_w(WIDTH);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] rem, shifted, diff, r_step;
  logic [WIDTH-1:0] q, dvs, q_next, r_next, a_mag, b_mag, q_fin, r_fin;
  logic cout, unused_msb;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  // q holds the unconsumed dividend bits on top and the quotient bits shifted in below.
  assign shifted = {rem[WIDTH-1:0], q[WIDTH-1]};
  assign r_step = cout ? diff : shifted;
  assign q_next = {q[WIDTH-2:0], cout};
  assign r_next = r_step[WIDTH-1:0];
  assign unused_msb = rem[WIDTH];
  cla_sub_nbit #(.N(WIDTH + 1)) u_sub (
    .a   (shifted),
    .b   ({1'b0, dvs}),
    .diff(diff),
    .cout(cout)
  );
`ifdef RESTORING_DIV_SIGNED_EN
  logic qneg, rneg;
  assign a_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign b_mag = divisor[WIDTH-1] ? -divisor : divisor;
  assign q_fin = qneg ? -q_next : q_next;
  assign r_fin = rneg ? -r_next : r_next;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      qneg <= 1'b0;
      rneg <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      qneg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      rneg <= dividend[WIDTH-1];
    end
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign q_fin = q_next;
  assign r_fin = r_next;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (state == IDLE) nxt = in_valid ? (divisor == '0 ? DONE : BUSY) : IDLE;
    else if (state == BUSY) nxt = cnt == CW'(1) ? DONE : BUSY;
    else nxt = out_ready ? IDLE : DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      rem <= '0;
      q <= '0;
      dvs <= '0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      if (divisor == '0) begin
        quotient <= '1;
        remainder <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        q <= a_mag;
        dvs <= b_mag;
        rem <= '0;
        cnt <= CW'(WIDTH);
        div_by_zero <= 1'b0;
      end
    end else if (state == BUSY) begin
      q <= q_next;
      rem <= r_step;
      cnt <= cnt - CW'(1);
      // Last step: publish the result (sign fix-up applied) as DONE is entered.
      if (cnt == CW'(1)) begin
        quotient <= q_fin;
        remainder <= r_fin;
      end
    end
endmodule

// File: tb/tb_restoring_div.sv
// tb_restoring_div: directed vectors for restoring_div (WIDTH=8) with hand-computed results.
module tb_restoring_div;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic in_ready, out_valid, div_by_zero;
  logic [7:0] quotient, remainder;
  int n_checks = 0;
  int n_fail = 0;

  restoring_div #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b, input int hold,
                     input logic [7:0] eq, input logic [7:0] er, input logic ez, input int elat);
    int n;
    logic busy_ok;
    @(negedge clk);
    check({tag, " in_ready before"}, in_ready, 1);
    in_valid = 1'b1;
    dividend = a;
    divisor = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 1;
    busy_ok = 1'b1;
    while (!out_valid && n < 40) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " latency"}, n, elat);
    check({tag, " in_ready low while busy"}, busy_ok, 1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, " held valid"}, {in_ready, out_valid, quotient, remainder}, {1'b0, 1'b1, eq, er});
    end
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_by_zero"}, div_by_zero, ez);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, " handoff"}, {out_valid, in_ready}, 2'b01);
    check({tag, " outputs kept"}, {quotient, remainder}, {eq, er});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset state", {in_ready, out_valid, quotient, remainder, div_by_zero}, {2'b10, 16'h0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
`ifdef RESTORING_DIV_SIGNED_EN
    run("s -7/2", 8'hF9, 8'h02, 0, 8'hFD, 8'hFF, 1'b0, 9);
    run("s -128/-1", 8'h80, 8'hFF, 0, 8'h80, 8'h00, 1'b0, 9);
    run("s 7/-2", 8'h07, 8'hFE, 0, 8'hFD, 8'h01, 1'b0, 9);
    run("s 5/0", 8'h05, 8'h00, 0, 8'hFF, 8'h05, 1'b1, 1);
`else
    run("200/7", 8'd200, 8'd7, 0, 8'h1C, 8'h04, 1'b0, 9);
    run("255/1", 8'd255, 8'd1, 0, 8'hFF, 8'h00, 1'b0, 9);
    run("0/13", 8'd0, 8'd13, 0, 8'h00, 8'h00, 1'b0, 9);
    run("13/200", 8'd13, 8'd200, 0, 8'h00, 8'h0D, 1'b0, 9);
    run("255/255", 8'd255, 8'd255, 0, 8'h01, 8'h00, 1'b0, 9);
    run("5/0", 8'd5, 8'd0, 0, 8'hFF, 8'h05, 1'b1, 1);
    run("100/10 stall", 8'd100, 8'd10, 5, 8'h0A, 8'h00, 1'b0, 9);
`endif
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 8'd200;
    divisor = 8'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid-op busy", {in_ready, out_valid}, 2'b00);
    rst_n = 1'b0;
    #1;
    check("mid-op reset", {in_ready, out_valid, quotient, remainder, div_by_zero}, {2'b10, 16'h0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    run("9/3 after reset", 8'd9, 8'd3, 0, 8'h03, 8'h00, 1'b0, 9);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
